// File: rtl/clk_div_mon_pkg.sv
// Shared types and default parameters for the divided-clock period monitor.
package clk_div_mon_pkg;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_LOCK_CNT    = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int ERR_W           = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous clock input, followed by a
// rising-edge detector in the clk_in domain.
module sync_edge_det
    import clk_div_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the period of mon_clk in clk_in cycles, checks it against an
// expected period with tolerance, and reports lock, errors and timeouts.
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_CNT    = DEF_LOCK_CNT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             mon_clk,
    input  logic             enable,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [3:0]       tol,
    input  logic             err_clr,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             period_err,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int                 RUN_W   = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0]   RUN_MAX = RUN_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [CNT_W-1:0]   meas_period_d;
    logic               meas_valid_d, locked_d, period_err_d, timeout_d;
    logic [ERR_W-1:0]   err_cnt_d;
    logic               rise;

    logic signed [CNT_W:0] diff;
    logic        [CNT_W:0] abs_diff;
    logic                  good;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in  (clk_in),
        .reset   (reset),
        .async_in(mon_clk),
        .rise    (rise)
    );

    // One extra bit keeps the signed difference exact across the full counter range.
    assign diff     = $signed({1'b0, cnt_q}) - $signed({1'b0, exp_period});
    assign abs_diff = diff[CNT_W] ? unsigned'(-diff) : unsigned'(diff);
    assign good     = abs_diff <= {{(CNT_W - 3){1'b0}}, tol};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        run_d         = run_q;
        meas_period_d = meas_period;
        meas_valid_d  = 1'b0;
        locked_d      = locked;
        period_err_d  = 1'b0;
        timeout_d     = timeout;

        if (!enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            run_d     = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_EDGE;

                WAIT_EDGE: begin
                    if (rise) begin
                        state_d   = MEASURE;
                        cnt_d     = CNT_W'(1);
                        timeout_d = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        // Counter parks at max; only the first arrival raises the error.
                        period_err_d = ~timeout;
                        timeout_d    = 1'b1;
                        run_d        = '0;
                        locked_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                MEASURE: begin
                    locked_d = locked | (run_q == RUN_MAX);
                    if (rise) begin
                        cnt_d         = CNT_W'(1);
                        meas_period_d = cnt_q;
                        meas_valid_d  = 1'b1;
                        if (good) begin
                            if (run_q != RUN_MAX) run_d = run_q + 1'b1;
                        end else begin
                            run_d        = '0;
                            locked_d     = 1'b0;
                            period_err_d = 1'b1;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_d      = WAIT_EDGE;
                        timeout_d    = 1'b1;
                        period_err_d = 1'b1;
                        run_d        = '0;
                        locked_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // The error counter tracks the registered period_err pulse one cycle later.
    always_comb begin
        err_cnt_d = err_cnt;
        if (err_clr) begin
            err_cnt_d = period_err ? ERR_W'(1) : '0;
        end else if (period_err && (err_cnt != '1)) begin
            err_cnt_d = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_q       <= '0;
            meas_period <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            period_err  <= 1'b0;
            timeout     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            meas_period <= meas_period_d;
            meas_valid  <= meas_valid_d;
            locked      <= locked_d;
            period_err  <= period_err_d;
            timeout     <= timeout_d;
            err_cnt     <= err_cnt_d;
        end
    end

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of period counter and measurement outputs.
REQ-002 SHALL have parameter LOCK_CNT, default 4, consecutive good periods required for lock.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on mon_clk (minimum 2).
REQ-004 SHALL have port clk_in  input  1  reference clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mon_clk  input  1  divided clock under test, treated as asynchronous.
REQ-007 SHALL have port enable  input  1  monitor run; 0 forces IDLE.
REQ-008 SHALL have port exp_period  input  CNT_W  expected period in clk_in cycles.
REQ-009 SHALL have port tol  input  4  allowed absolute deviation in cycles.
REQ-010 SHALL have port err_clr  input  1  single-cycle clear of err_cnt.
REQ-011 SHALL have port meas_period  output  CNT_W  last measured period.
REQ-012 SHALL have port meas_valid  output  1  one-cycle pulse when meas_period updates.
REQ-013 SHALL have port locked  output  1  LOCK_CNT consecutive in-tolerance periods seen.
REQ-014 SHALL have port period_err  output  1  one-cycle pulse on out-of-tolerance period or timeout.
REQ-015 SHALL have port timeout  output  1  sticky; no mon_clk edge within 2^CNT_W-1 cycles; cleared on next detected edge.
REQ-016 SHALL have port err_cnt  output  8  saturating count of period_err pulses.

Function
REQ-017 SHALL pass mon_clk through SYNC_STAGES flops, then detect a rising edge as sync_out=1 while the previous sample=0.
REQ-018 SHALL implement FSM states IDLE, WAIT_EDGE, MEASURE.
REQ-019 SHALL transition IDLE->WAIT_EDGE when enable=1, and from any state ->IDLE on the cycle after enable=0.
REQ-020 SHALL go WAIT_EDGE->MEASURE on a detected edge, loading cnt=1; no measurement is produced for this first edge.
REQ-021 SHALL, in MEASURE, on each detected edge, load meas_period<=cnt, pulse meas_valid, and set cnt<=1; otherwise increment cnt.
REQ-022 SHALL deem a period good iff |cnt-exp_period| <= tol, computed at CNT_W+1 bits signed without wrap.
REQ-023 SHALL, on a good period, increment good_run, saturating at LOCK_CNT, and assert locked the cycle after good_run reaches LOCK_CNT.
REQ-024 SHALL, on a bad period, clear good_run, deassert locked, pulse period_err and increment err_cnt saturating at 255.
REQ-025 SHALL, when cnt reaches 2^CNT_W-1 in MEASURE or WAIT_EDGE, set timeout, pulse period_err once, clear locked and good_run, and go to WAIT_EDGE.
REQ-026 SHALL make err_cnt=1 when err_clr and period_err coincide, and 0 on err_clr alone.
REQ-027 SHALL, on leaving to IDLE, clear cnt, good_run, locked and timeout, while holding meas_period and err_cnt.
REQ-028 SHALL give a latency from a mon_clk rise to meas_valid of SYNC_STAGES+1 clk_in cycles.

Reset
REQ-029 SHALL, on reset, force state=IDLE and cnt=0, good_run=0, meas_period=0, meas_valid=0, locked=0, period_err=0, timeout=0, err_cnt=0, and all sync flops=0.
REQ-030 SHALL let reset dominate enable and err_clr, and SHALL abort a measurement in progress with no meas_valid.

Structure
REQ-031 SHALL put the state enum, default parameter values, and err_cnt width in package clk_div_mon_pkg.
REQ-032 SHALL implement the synchronizer and edge detector as sub-module sync_edge_det (parameter SYNC_STAGES), instantiated once.

Verification
REQ-033 SHALL cover: mon_clk from the divide-by-3 block, exp_period=3, tol=0 -> meas_period=3 each period, locked after 4th measurement, err_cnt=0.
REQ-034 SHALL cover: locked, then one mon_clk period stretched to 5, tol=0 -> period_err pulse, locked=0, err_cnt=1, relock after 4 good periods.
REQ-035 SHALL cover: mon_clk held low with CNT_W=8 -> timeout=1 and a single period_err after 255 cycles; timeout clears on next edge.
REQ-036 SHALL cover: enable dropped mid-MEASURE -> IDLE next cycle, locked=0, meas_period and err_cnt held.
REQ-037 SHALL cover: err_clr coincident with period_err at err_cnt=7 -> err_cnt=1; 300 errors -> err_cnt=255.
REQ-038 SHALL cover: reset asserted mid-measurement -> all outputs 0 next cycle, no meas_valid.
